// File: rtl/ssd_share_arbiter.sv
// Round-robin share of a 4-digit seven-segment display between an adder (A) and a multiplier (B).
// gnt is 1 cycle after req; seg/an are registered 1 cycle behind the scan. Optional SSD_LZ_BLANK_EN blanks leading zeros.
module ssd_share_arbiter #(
  parameter int SCAN_BITS   = 16,
  parameter int HOLD_FRAMES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_b,
  output logic        owner,
  output logic        valid,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [11:0] HOLD_INIT = 12'(HOLD_FRAMES);

  state_t               state;
  logic [SCAN_BITS-1:0] presc;
  logic [1:0]           idx;
  logic [11:0]          hold_cnt;
  logic                 ptr;
  logic [15:0]          disp;

  logic       tick;
  logic       frame_end;
  logic       eff_a;
  logic       eff_b;
  logic       pick;
  logic [3:0] nib;
  logic       blank;

  function automatic logic [6:0] ssd_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick      = &presc;
  assign frame_end = tick && (idx == 2'd3);

  // A request is still high during its own gnt cycle; it must not be granted twice.
  assign eff_a = req_a & ~gnt_a;
  assign eff_b = req_b & ~gnt_b;
  assign pick  = ptr ? eff_b : ~eff_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      idx      <= 2'd0;
      hold_cnt <= 12'd0;
      ptr      <= 1'b0;
      disp     <= 16'h0000;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      owner    <= 1'b0;
      valid    <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      if (tick) idx <= idx + 2'd1;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      if (state == IDLE) begin
        if (eff_a || eff_b) begin
          gnt_a    <= ~pick;
          gnt_b    <= pick;
          disp     <= pick ? data_b : data_a;
          owner    <= pick;
          valid    <= 1'b1;
          hold_cnt <= HOLD_INIT;
          ptr      <= ~pick;
          state    <= HOLD;
        end
      end else begin
        // Owner refresh keeps the original hold deadline and pointer.
        if (owner ? eff_b : eff_a) begin
          gnt_a <= ~owner;
          gnt_b <= owner;
          disp  <= owner ? data_b : data_a;
        end
        if (frame_end) begin
          hold_cnt <= hold_cnt - 12'd1;
          if (hold_cnt <= 12'd1) state <= IDLE;
        end
      end
    end
  end

  assign nib = disp[{idx, 2'b00} +: 4];

`ifdef SSD_LZ_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (disp[15:12] == 4'h0);
      2'd2:    blank = (disp[15:8]  == 8'h00);
      2'd1:    blank = (disp[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
    end else if (!valid) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= blank ? 7'b1111111 : ssd_decode(nib);
    end
  end

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Bench for ssd_share_arbiter: directed steps plus random requests checked against a frame-arithmetic reference model.
module tb_ssd_share_arbiter;

  localparam int SB = 2;
  localparam int HF = 2;
  localparam int DP = 1 << SB;
  localparam int FR = 4 * DP;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [15:0] data_a = 16'h0;
  logic [15:0] data_b = 16'h0;
  logic        gnt_a, gnt_b, owner, valid;
  logic [6:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  ssd_share_arbiter #(.SCAN_BITS(SB), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .owner(owner), .valid(valid), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Reference model state for the current cycle; hold ends after the last frame-end cycle m_f.
  int          cyc;
  bit          m_hold, m_owner, m_valid, m_ptr, m_ga, m_gb;
  int          m_f;
  logic [15:0] m_disp;
  bit          p_live, p_valid;
  logic [15:0] p_disp;
  int          p_idx;
  bit          saw_ga, saw_gb;
  int          n_gb;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_hold = 0; m_owner = 0; m_valid = 0; m_ptr = 0;
    m_ga = 0; m_gb = 0; m_f = 0; m_disp = 16'h0;
    p_live = 0; p_valid = 0; p_disp = 16'h0; p_idx = 0;
  endtask

  task automatic grant(input bit side, input logic [15:0] d);
    if (side) m_gb = 1; else m_ga = 1;
    m_disp  = d;
    m_owner = side;
    m_valid = 1;
  endtask

  task automatic model_step(input bit ra, input bit rb, input logic [15:0] da, input logic [15:0] db);
    bit ea, eb, pick;
    int g, first;
    if (m_hold && cyc > m_f) m_hold = 0;
    ea = ra && !m_ga;
    eb = rb && !m_gb;
    p_live = 1; p_valid = m_valid; p_disp = m_disp; p_idx = (cyc / DP) % 4;
    m_ga = 0; m_gb = 0;
    if (!m_hold) begin
      if (ea || eb) begin
        if (!m_ptr) pick = ea ? 1'b0 : 1'b1;
        else        pick = eb ? 1'b1 : 1'b0;
        grant(pick, pick ? db : da);
        m_ptr  = !pick;
        m_hold = 1;
        g      = cyc + 1;
        first  = g + (FR - 1) - (g % FR);
        m_f    = first + FR * (HF - 1);
      end
    end else if (!m_owner && ea) begin
      grant(1'b0, da);
    end else if (m_owner && eb) begin
      grant(1'b1, db);
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [6:0]  es;
    logic [3:0]  ean;
    logic [15:0] sh;
    bit          blank;
    if (!p_live || !p_valid) begin
      es  = 7'b1111111;
      ean = 4'b1111;
    end else begin
      ean   = 4'hF ^ (4'h1 << p_idx);
      sh    = p_disp >> (4 * p_idx);
      blank = 0;
`ifdef SSD_LZ_BLANK_EN
      blank = (p_idx > 0) && (sh == 16'h0);
`endif
      es = blank ? 7'b1111111 : hex7(sh[3:0]);
    end
    chk("gnt_a", 16'(gnt_a), 16'(m_ga));
    chk("gnt_b", 16'(gnt_b), 16'(m_gb));
    chk("owner", 16'(owner), 16'(m_owner));
    chk("valid", 16'(valid), 16'(m_valid));
    chk("seg",   16'(seg),   16'(es));
    chk("an",    16'(an),    16'(ean));
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    saw_ga = gnt_a;
    saw_gb = gnt_b;
    if (gnt_b) n_gb++;
    model_step(req_a, req_b, data_a, data_b);
    @(posedge clk);
    #1;
    if (saw_ga) req_a = 1'b0;
    if (saw_gb) req_b = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic raise_a(input logic [15:0] d);
    data_a = d;
    req_a  = 1'b1;
  endtask

  task automatic raise_b(input logic [15:0] d);
    data_b = d;
    req_b  = 1'b1;
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_gnt_a", 16'(gnt_a), 16'h0);
    chk("rst_gnt_b", 16'(gnt_b), 16'h0);
    chk("rst_owner", 16'(owner), 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_seg",   16'(seg),   16'h7F);
    chk("rst_an",    16'(an),    16'hF);
    model_reset();
    req_a = 1'b0;
    req_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int nb0;
    model_reset();
    n_gb = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle after reset: display dark, nothing valid.
    run(100);
    do_reset();

    // Single A request and one full digit scan.
    raise_a(16'h12AF);
    run(24);
    do_reset();

    // Simultaneous requests after reset: A first, B after A's hold.
    nb0 = n_gb;
    raise_a(16'($urandom));
    raise_b(16'h00B3);
    run(50);
    chk("b_granted_after_a_hold", 16'(n_gb - nb0), 16'd1);

    // During B hold: B refresh and a waiting A request.
    raise_b(16'h0007);
    raise_a(16'h5555);
    run(65);

    // Idle again with pointer on B: simultaneous requests go to B.
    raise_a(16'($urandom));
    raise_b(16'($urandom));
    run(90);

    // Leading-zero value.
    raise_a(16'h0040);
    run(60);

    // Non-owner request withdrawn before grant.
    raise_b(16'($urandom));
    run(3);
    raise_a(16'hBEEF);
    run(3);
    req_a = 1'b0;
    run(50);

    for (int i = 0; i < 2500; i++) begin
      step();
      if (!req_a && $urandom_range(0, 9) == 0) raise_a(16'($urandom));
      else if (req_a && $urandom_range(0, 59) == 0) req_a = 1'b0;
      if (!req_b && $urandom_range(0, 9) == 0) raise_b(16'($urandom));
      else if (req_b && $urandom_range(0, 59) == 0) req_b = 1'b0;
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
